// File: rtl/out_spike_packetizer.sv
// out_spike_packetizer: gathers per-timestep output spikes and, on flush, streams
// one single-flit packet per fired neuron (ascending id) to the router local port.
module out_spike_packetizer #(
   parameter int NUM_NEURONS          = 256,
   parameter int NEURON_CNT_BIT_WIDTH = 8,
   parameter int COORD_WIDTH          = 4,
   parameter int X_COORD              = 1,
   parameter int Y_COORD              = 1
) (
   input  logic                                        clk_i,
   input  logic                                        rst_n_i,
   input  logic                                        spike_wr_en_i,
   input  logic [NEURON_CNT_BIT_WIDTH-1:0]             spike_addr_i,
   input  logic                                        spike_i,
   input  logic                                        flush_i,
   output logic [2*COORD_WIDTH+NEURON_CNT_BIT_WIDTH-1:0] pkt_o,
   output logic                                        pkt_valid_o,
   input  logic                                        pkt_ready_i,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic                                        overrun_o,
   output logic [NEURON_CNT_BIT_WIDTH:0]               spike_cnt_o
);
   localparam int CNT_W = NEURON_CNT_BIT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

   state_t                          state, state_nxt;
   logic [NUM_NEURONS-1:0]          acc_buf, tx_buf, acc_wr;
   logic [NEURON_CNT_BIT_WIDTH-1:0] idx;
   logic                            last, hit, hs, flush_ok;

   // a write landing in the flush cycle is folded into the snapshot
   always_comb begin
      acc_wr = acc_buf;
      if (spike_wr_en_i) acc_wr[spike_addr_i] = spike_i;
   end

   assign last     = &idx;
   assign hit      = tx_buf[idx];
   assign hs       = (state == SEND) && pkt_ready_i;
   assign flush_ok = flush_i && (state == IDLE);
   assign busy_o   = state != IDLE;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: state_nxt = flush_i ? SCAN : IDLE;
         SCAN: state_nxt = hit ? SEND : (last ? DONE : SCAN);
         SEND: state_nxt = pkt_ready_i ? (last ? DONE : SCAN) : SEND;
         DONE: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_buf     <= '0;
         tx_buf      <= '0;
         idx         <= '0;
         pkt_o       <= '0;
         pkt_valid_o <= 1'b0;
         done_o      <= 1'b0;
         overrun_o   <= 1'b0;
         spike_cnt_o <= '0;
      end else begin
         acc_buf   <= flush_ok ? '0 : acc_wr;
         overrun_o <= flush_i && (state != IDLE);
         done_o    <= state == DONE;
         if (flush_ok) begin
            tx_buf      <= acc_wr;
            idx         <= '0;
            spike_cnt_o <= '0;
         end
         if (state == SCAN && hit) begin
            pkt_o       <= {COORD_WIDTH'(X_COORD), COORD_WIDTH'(Y_COORD), idx};
            pkt_valid_o <= 1'b1;
         end
         if (state == SCAN && !hit && !last) idx <= idx + NEURON_CNT_BIT_WIDTH'(1);
         // handshake retires the bit and forces a SCAN cycle before the next flit
         if (hs) begin
            pkt_valid_o  <= 1'b0;
            spike_cnt_o  <= spike_cnt_o + CNT_W'(1);
            tx_buf[idx]  <= 1'b0;
            if (!last) idx <= idx + NEURON_CNT_BIT_WIDTH'(1);
         end
      end
   end
endmodule
